wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage of the 5-stage pipeline; it consumes the outputs of the MEM/WB latch.
- Selects the writeback value, writes the 32x32 register file it contains, and serves the two decode-stage read ports with write-through bypass.
- Publishes a forwarding tap to the hazard/forward unit, latches HALT, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W).
- RST_SP, 32'h0000FFFC, value loaded into r29 at reset; all other registers reset to 0.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- wb_valid  input  1  MEM/WB latch holds a live instruction this cycle; low for bubble/stall.
- dmemload_out  input  32  load data from the MEM/WB latch.
- aluout_out  input  32  ALU result from the MEM/WB latch.
- npc_out  input  32  PC+4 from the MEM/WB latch.
- imm_out  input  16  immediate from the MEM/WB latch.
- dest_out  input  5  destination register.
- WBctrl_out  input  4  bit0 RegWr; bits[2:1] source select (00 ALU, 01 mem, 10 npc, 11 LUI); bit3 HALT.
- instr_out  input  32  instruction word, used only for retire qualification.
- rsel1, rsel2  input  5  decode read selects.
- rdat1, rdat2  output  32  decode read data.
- fwd_valid  output  1  a register write is happening this cycle.
- fwd_dest  output  5  register being written.
- fwd_data  output  32  value being written.
- halt  output  1  sticky halt flag.
- retired  output  CNT_W  count of retired instructions.

Behaviour:
- Reset (nRST low, asynchronous):
  - registers r0..r31 = 0 except r29 = RST_SP.
  - halt = 0; retired = 0.
  - Combinational outputs follow the reset state.
- Writeback value wdat:
  - sel 00 -> aluout_out.
  - sel 01 -> dmemload_out.
  - sel 10 -> npc_out.
  - sel 11 -> {imm_out, 16'h0000}.
- Write enable we = wb_valid & WBctrl_out[0] & ~WBctrl_out[3] & (dest_out != 0) & ~halt.
  - On the rising edge with we=1, reg[dest_out] <= wdat.
- r0 always reads 0, including when dest_out = 0 with RegWr set: the write is dropped.
- Reads are combinational. If we=1 and rselN == dest_out (nonzero), rdatN = wdat (same-cycle bypass); otherwise rdatN = reg[rselN].
- Forwarding tap is combinational: fwd_valid = we, fwd_dest = dest_out, fwd_data = wdat. When fwd_valid = 0, fwd_dest and fwd_data are don't-care but driven (no X).
- HALT:
  - wb_valid & WBctrl_out[3] sets halt on the next edge; halt stays set until reset.
  - The HALT instruction itself never writes.
  - After halt = 1, all writes and retire counting are suppressed even if wb_valid stays high.
- Retire: on each edge with wb_valid & ~halt & (instr_out != 0), retired <= retired + 1.
  - The HALT instruction counts.
  - NOPs (all-zero word) and bubbles do not count.
  - Counter wraps at 2^CNT_W.
- Simultaneous write and read of the same register: the reader sees the new value (bypass), and the stored value updates at the edge.
- nRST asserted mid-write: reset wins, and the register holds its reset value.
- Latency: write visible through bypass in cycle 0 and from storage from cycle 1 onward; halt visible 1 cycle after the HALT enters WB.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined: the retired counter is implemented as above.
- Undefined: no counter flops; retired is tied to 0 for all time.
- All other behaviour is identical in both builds.

Test Plan:
- Reset value: assert nRST=0 mid-cycle -> immediately rdat of r29 = 32'h0000FFFC, all others 0, halt=0, retired=0.
- ALU write and bypass: wb_valid=1, WBctrl=4'b0001, dest=5, aluout=32'hDEADBEEF, rsel1=5.
  - Same cycle: rdat1=32'hDEADBEEF and fwd_valid=1.
  - Next cycle with wb_valid=0: rdat1 still 32'hDEADBEEF.
- Source select: dest=8 with sel 01 / 10 / 11, using dmemload=32'h12345678, npc=32'h00000044, imm=16'hABCD:
  - sel 01 -> r8 = 32'h12345678.
  - sel 10 -> r8 = 32'h00000044.
  - sel 11 -> r8 = 32'hABCD0000.
- r0 protection: RegWr=1, dest=0, aluout=32'hFFFFFFFF -> rdat1(rsel1=0) = 0 in the same cycle and the next; fwd_valid = 0.
- Halt: HALT with wb_valid=1, then a RegWr to r3 with value 7 on the following cycle.
  - halt=1 one edge after the HALT.
  - r3 unchanged.
  - retired increments once for the HALT and never again.
- Retire filtering: 3 valid nonzero instructions, 2 NOPs (instr=0), 2 cycles with wb_valid=0 -> retired = 3; with WB_RETIRE_CNT_EN undefined -> retired = 0.

Source files
------------

// File: rtl/wb_stage_if.sv
// Bundle between the MEM/WB latch, the decode read ports and the hazard unit
// on one side and the writeback stage on the other.
// master: the pipeline around the stage (drives latch fields and read selects).
// slave:  the writeback stage itself.
interface wb_stage_if #(
  parameter int CNT_W = 32
);
  logic             wb_valid;
  logic [31:0]      dmemload_out;
  logic [31:0]      aluout_out;
  logic [31:0]      npc_out;
  logic [15:0]      imm_out;
  logic [4:0]       dest_out;
  logic [3:0]       WBctrl_out;
  logic [31:0]      instr_out;
  logic [4:0]       rsel1;
  logic [4:0]       rsel2;
  logic [31:0]      rdat1;
  logic [31:0]      rdat2;
  logic             fwd_valid;
  logic [4:0]       fwd_dest;
  logic [31:0]      fwd_data;
  logic             halt;
  logic [CNT_W-1:0] retired;

  modport master (
    output wb_valid, dmemload_out, aluout_out, npc_out, imm_out,
           dest_out, WBctrl_out, instr_out, rsel1, rsel2,
    input  rdat1, rdat2, fwd_valid, fwd_dest, fwd_data, halt, retired
  );

  modport slave (
    input  wb_valid, dmemload_out, aluout_out, npc_out, imm_out,
           dest_out, WBctrl_out, instr_out, rsel1, rsel2,
    output rdat1, rdat2, fwd_valid, fwd_dest, fwd_data, halt, retired
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: selects the writeback value, owns the 32x32 register file
// with write-through bypass on both decode read ports, publishes the
// forwarding tap, latches HALT and counts retired instructions.
// Optional build macro WB_RETIRE_CNT_EN: when defined the retired-instruction
// counter is built; otherwise retired is tied to zero and no counter flops exist.
module wb_stage #(
  parameter int          CNT_W  = 32,
  parameter logic [31:0] RST_SP = 32'h0000FFFC
) (
  input logic       CLK,
  input logic       nRST,
  wb_stage_if.slave bus
);

  logic [31:0] regs_q [32];
  logic        halt_q;
  logic        halt_d;
  logic [31:0] wbData;
  logic        writeEn;

  // Writeback value from the source-select field of the control word
  always_comb begin
    wbData = bus.aluout_out;
    unique case (bus.WBctrl_out[2:1])
      2'b00:   wbData = bus.aluout_out;
      2'b01:   wbData = bus.dmemload_out;
      2'b10:   wbData = bus.npc_out;
      default: wbData = {bus.imm_out, 16'h0000};
    endcase
  end

  // A write needs a live, non-HALT RegWr to a nonzero register while not halted
  always_comb begin
    writeEn = bus.wb_valid & bus.WBctrl_out[0] & ~bus.WBctrl_out[3]
            & (bus.dest_out != 5'd0) & ~halt_q;
  end

  // Register file storage; r29 comes out of reset holding the initial stack pointer
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == 29) ? RST_SP : 32'h0;
      end
    end else if (writeEn) begin
      regs_q[bus.dest_out] <= wbData;
    end
  end

  // Decode read ports; a same-cycle write to the selected register is bypassed
  always_comb begin
    bus.rdat1 = regs_q[bus.rsel1];
    bus.rdat2 = regs_q[bus.rsel2];
    if (writeEn && (bus.rsel1 == bus.dest_out)) begin
      bus.rdat1 = wbData;
    end
    if (writeEn && (bus.rsel2 == bus.dest_out)) begin
      bus.rdat2 = wbData;
    end
  end

  // Forwarding tap mirrors the write currently in progress
  always_comb begin
    bus.fwd_valid = writeEn;
    bus.fwd_dest  = bus.dest_out;
    bus.fwd_data  = wbData;
  end

  // Halt becomes sticky once a live HALT reaches writeback
  always_comb begin
    halt_d = halt_q | (bus.wb_valid & bus.WBctrl_out[3]);
  end

  // Halt flag register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end

  assign bus.halt = halt_q;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] retired_d;
  logic             retireEn;

  // Live, nonzero instructions retire until halted; the HALT itself still counts
  always_comb begin
    retireEn  = bus.wb_valid & ~halt_q & (bus.instr_out != 32'h0);
    retired_d = retired_q;
    if (retireEn) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  // Retired-instruction counter, wrapping naturally at its width
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign bus.retired = retired_q;
`else
  logic unusedRetireInputs;

  assign unusedRetireInputs = ^bus.instr_out;
  assign bus.retired        = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus a randomized run,
// all compared against a behavioural register-file model.
module tb_wb_stage;

  localparam logic [31:0] SP_INIT = 32'h0000FFFC;

  logic CLK;
  logic nRST;

  wb_stage_if #(.CNT_W(32)) bus ();

  wb_stage #(.CNT_W(32), .RST_SP(SP_INIT)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int nCompared;
  int nMismatched;

  logic [31:0] mRegs [32];
  logic        mHalt;
  logic [31:0] mRetired;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void modelReset();
    for (int i = 0; i < 32; i++) mRegs[i] = (i == 29) ? SP_INIT : 32'h0;
    mHalt    = 1'b0;
    mRetired = 32'h0;
  endfunction

  function automatic logic [31:0] expWdat();
    case (bus.WBctrl_out[2:1])
      2'b00:   return bus.aluout_out;
      2'b01:   return bus.dmemload_out;
      2'b10:   return bus.npc_out;
      default: return {bus.imm_out, 16'h0000};
    endcase
  endfunction

  function automatic logic expWrite();
    if (!bus.wb_valid || mHalt) return 1'b0;
    if (bus.WBctrl_out[3] || !bus.WBctrl_out[0]) return 1'b0;
    return bus.dest_out != 5'd0;
  endfunction

  function automatic logic [31:0] expRead(input logic [4:0] sel);
    if (sel == 5'd0) return 32'h0;
    if (expWrite() && sel == bus.dest_out) return expWdat();
    return mRegs[sel];
  endfunction

  function automatic logic [31:0] expRetired();
`ifdef WB_RETIRE_CNT_EN
    return mRetired;
`else
    return 32'h0;
`endif
  endfunction

  function automatic void modelCommit();
    logic doWrite;
    doWrite = expWrite();
    if (doWrite) mRegs[bus.dest_out] = expWdat();
    if (bus.wb_valid && !mHalt && bus.instr_out != 32'h0) mRetired = mRetired + 32'd1;
    if (bus.wb_valid && bus.WBctrl_out[3]) mHalt = 1'b1;
  endfunction

  task automatic drive(input logic v, input logic [3:0] c, input logic [4:0] d,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] npc, input logic [15:0] imm,
                       input logic [31:0] ins, input logic [4:0] r1,
                       input logic [4:0] r2);
    bus.wb_valid     = v;
    bus.WBctrl_out   = c;
    bus.dest_out     = d;
    bus.aluout_out   = alu;
    bus.dmemload_out = mem;
    bus.npc_out      = npc;
    bus.imm_out      = imm;
    bus.instr_out    = ins;
    bus.rsel1        = r1;
    bus.rsel2        = r2;
  endtask

  task automatic advance();
    modelCommit();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulseReset();
    @(negedge CLK);
    nRST = 1'b0;
    modelReset();
    #2;
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    drive(1'b0, 4'h0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0, 32'h0, 5'd0, 5'd0);
    @(posedge CLK);
    #3;
    nRST = 1'b0;
    modelReset();
    #1;
    for (int i = 0; i < 32; i++) begin
      bus.rsel1 = 5'(i);
      bus.rsel2 = 5'(31 - i);
      #1;
      exp = (i == 29) ? 32'h0000FFFC : 32'h0;
      nCompared++;
      if (bus.rdat1 !== exp) begin
        nMismatched++;
        $display("[TB] FAIL reset_rdat1 r%0d: got %h expected %h", i, bus.rdat1, exp);
      end
      exp = ((31 - i) == 29) ? 32'h0000FFFC : 32'h0;
      nCompared++;
      if (bus.rdat2 !== exp) begin
        nMismatched++;
        $display("[TB] FAIL reset_rdat2 r%0d: got %h expected %h", 31 - i, bus.rdat2, exp);
      end
    end
    nCompared++;
    if (bus.halt !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_halt: got %b expected 0", bus.halt);
    end
    nCompared++;
    if (bus.retired !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_retired: got %0d expected 0", bus.retired);
    end
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    // write to r29 in flight when reset hits: reset must win
    drive(1'b1, 4'b0001, 5'd29, 32'h11111111, 32'h0, 32'h0, 16'h0, 32'h1, 5'd29, 5'd0);
    @(negedge CLK);
    nRST = 1'b0;
    modelReset();
    @(posedge CLK);
    #1;
    drive(1'b0, 4'h0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0, 32'h0, 5'd29, 5'd0);
    #1;
    nCompared++;
    if (bus.rdat1 !== 32'h0000FFFC) begin
      nMismatched++;
      $display("[TB] FAIL reset_mid_write: got %h expected 0000fffc", bus.rdat1);
    end
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_alu_bypass();
    drive(1'b1, 4'b0001, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0, 16'h0, 32'h00A52020, 5'd5, 5'd0);
    @(negedge CLK);
    nCompared++;
    if (bus.rdat1 !== 32'hDEADBEEF) begin
      nMismatched++;
      $display("[TB] FAIL alu_bypass_rdat1: got %h expected deadbeef", bus.rdat1);
    end
    nCompared++;
    if (bus.fwd_valid !== 1'b1 || bus.fwd_dest !== 5'd5 || bus.fwd_data !== 32'hDEADBEEF) begin
      nMismatched++;
      $display("[TB] FAIL alu_fwd: got %b/%0d/%h expected 1/5/deadbeef",
               bus.fwd_valid, bus.fwd_dest, bus.fwd_data);
    end
    advance();
    drive(1'b0, 4'b0001, 5'd5, 32'h0, 32'h0, 32'h0, 16'h0, 32'h0, 5'd5, 5'd0);
    @(negedge CLK);
    nCompared++;
    if (bus.rdat1 !== 32'hDEADBEEF) begin
      nMismatched++;
      $display("[TB] FAIL alu_stored_rdat1: got %h expected deadbeef", bus.rdat1);
    end
    nCompared++;
    if (bus.fwd_valid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL bubble_fwd_valid: got %b expected 0", bus.fwd_valid);
    end
    advance();
  endtask

  task automatic test_source_select();
    logic [31:0] exp;
    logic [1:0]  s;
    for (int k = 1; k <= 3; k++) begin
      s = 2'(k);
      exp = (k == 1) ? 32'h12345678 : (k == 2) ? 32'h00000044 : 32'hABCD0000;
      drive(1'b1, {1'b0, s, 1'b1}, 5'd8, 32'h0BADF00D, 32'h12345678, 32'h00000044,
            16'hABCD, 32'h01084020, 5'd8, 5'd8);
      @(negedge CLK);
      nCompared++;
      if (bus.rdat1 !== exp) begin
        nMismatched++;
        $display("[TB] FAIL srcsel_bypass sel=%0d: got %h expected %h", k, bus.rdat1, exp);
      end
      advance();
      drive(1'b0, 4'h0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0, 32'h0, 5'd0, 5'd8);
      @(negedge CLK);
      nCompared++;
      if (bus.rdat2 !== exp) begin
        nMismatched++;
        $display("[TB] FAIL srcsel_stored sel=%0d: got %h expected %h", k, bus.rdat2, exp);
      end
      advance();
    end
  endtask

  task automatic test_r0_protect();
    drive(1'b1, 4'b0001, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 16'h0, 32'h00000020, 5'd0, 5'd0);
    @(negedge CLK);
    nCompared++;
    if (bus.rdat1 !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL r0_same_cycle: got %h expected 0", bus.rdat1);
    end
    nCompared++;
    if (bus.fwd_valid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL r0_fwd_valid: got %b expected 0", bus.fwd_valid);
    end
    advance();
    drive(1'b0, 4'h0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0, 32'h0, 5'd0, 5'd0);
    @(negedge CLK);
    nCompared++;
    if (bus.rdat1 !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL r0_next_cycle: got %h expected 0", bus.rdat1);
    end
    advance();
  endtask

  task automatic test_random();
    logic [3:0]  c;
    logic [4:0]  d;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] ins;
    for (int n = 0; n < 300; n++) begin
      c   = 4'($urandom) & 4'b0111;
      d   = 5'($urandom);
      r1  = ($urandom_range(0, 2) == 0) ? d : 5'($urandom);
      r2  = ($urandom_range(0, 2) == 0) ? d : 5'($urandom);
      ins = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      drive(1'($urandom_range(0, 3) != 0), c, d, $urandom, $urandom, $urandom,
            16'($urandom), ins, r1, r2);
      @(negedge CLK);
      nCompared++;
      if (bus.rdat1 !== expRead(r1)) begin
        nMismatched++;
        $display("[TB] FAIL rand_rdat1 n=%0d r%0d: got %h expected %h", n, r1, bus.rdat1, expRead(r1));
      end
      nCompared++;
      if (bus.rdat2 !== expRead(r2)) begin
        nMismatched++;
        $display("[TB] FAIL rand_rdat2 n=%0d r%0d: got %h expected %h", n, r2, bus.rdat2, expRead(r2));
      end
      nCompared++;
      if (bus.fwd_valid !== expWrite()) begin
        nMismatched++;
        $display("[TB] FAIL rand_fwd_valid n=%0d: got %b expected %b", n, bus.fwd_valid, expWrite());
      end
      if (expWrite()) begin
        nCompared++;
        if (bus.fwd_dest !== d || bus.fwd_data !== expWdat()) begin
          nMismatched++;
          $display("[TB] FAIL rand_fwd_tap n=%0d: got %0d/%h expected %0d/%h",
                   n, bus.fwd_dest, bus.fwd_data, d, expWdat());
        end
      end
      nCompared++;
      if ($isunknown({bus.fwd_dest, bus.fwd_data})) begin
        nMismatched++;
        $display("[TB] FAIL rand_fwd_known n=%0d: got %h/%h expected no X", n, bus.fwd_dest, bus.fwd_data);
      end
      nCompared++;
      if (bus.retired !== expRetired()) begin
        nMismatched++;
        $display("[TB] FAIL rand_retired n=%0d: got %0d expected %0d", n, bus.retired, expRetired());
      end
      advance();
    end
    drive(1'b0, 4'h0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      bus.rsel1 = 5'(i);
      #1;
      nCompared++;
      if (bus.rdat1 !== mRegs[i]) begin
        nMismatched++;
        $display("[TB] FAIL rand_regfile r%0d: got %h expected %h", i, bus.rdat1, mRegs[i]);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_retire_filter();
    logic        vTab [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] iTab [7] = '{32'h00221820, 32'h0, 32'h8C430004, 32'h0, 32'h00000001,
                              32'hFFFFFFFF, 32'h00642020};
    logic [31:0] exp;
    pulseReset();
    for (int k = 0; k < 7; k++) begin
      drive(vTab[k], 4'h0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0, iTab[k], 5'd0, 5'd0);
      advance();
    end
    drive(1'b0, 4'h0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0, 32'h0, 5'd0, 5'd0);
`ifdef WB_RETIRE_CNT_EN
    exp = 32'd3;
`else
    exp = 32'd0;
`endif
    @(negedge CLK);
    nCompared++;
    if (bus.retired !== exp) begin
      nMismatched++;
      $display("[TB] FAIL retire_filter: got %0d expected %0d", bus.retired, exp);
    end
    advance();
  endtask

  task automatic test_halt();
    logic [31:0] oldR3;
    logic [31:0] expRet;
    oldR3 = mRegs[3];
    expRet = expRetired();
`ifdef WB_RETIRE_CNT_EN
    expRet = expRet + 32'd1;
`endif
    drive(1'b1, 4'b1001, 5'd3, 32'd99, 32'h0, 32'h0, 16'h0, 32'hFC000000, 5'd3, 5'd0);
    @(negedge CLK);
    nCompared++;
    if (bus.fwd_valid !== 1'b0 || bus.rdat1 !== oldR3) begin
      nMismatched++;
      $display("[TB] FAIL halt_instr_nowrite: got %b/%h expected 0/%h", bus.fwd_valid, bus.rdat1, oldR3);
    end
    nCompared++;
    if (bus.halt !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL halt_early: got %b expected 0", bus.halt);
    end
    advance();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 4'b0001, 5'd3, 32'd7, 32'h0, 32'h0, 16'h0, 32'h00431820, 5'd3, 5'd3);
      @(negedge CLK);
      nCompared++;
      if (bus.halt !== 1'b1) begin
        nMismatched++;
        $display("[TB] FAIL halt_sticky k=%0d: got %b expected 1", k, bus.halt);
      end
      nCompared++;
      if (bus.fwd_valid !== 1'b0 || bus.rdat1 !== oldR3) begin
        nMismatched++;
        $display("[TB] FAIL halt_write_blocked k=%0d: got %b/%h expected 0/%h",
                 k, bus.fwd_valid, bus.rdat1, oldR3);
      end
      advance();
    end
    drive(1'b0, 4'h0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0, 32'h0, 5'd3, 5'd0);
    @(negedge CLK);
    nCompared++;
    if (bus.rdat1 !== oldR3) begin
      nMismatched++;
      $display("[TB] FAIL halt_r3_unchanged: got %h expected %h", bus.rdat1, oldR3);
    end
    nCompared++;
    if (bus.retired !== expRet) begin
      nMismatched++;
      $display("[TB] FAIL halt_retired: got %0d expected %0d", bus.retired, expRet);
    end
    advance();
  endtask

  // Run every scenario in order, then report
  initial begin
    nCompared   = 0;
    nMismatched = 0;
    nRST        = 1'b1;
    modelReset();
    test_reset();
    test_alu_bypass();
    test_source_select();
    test_r0_protect();
    test_random();
    test_retire_filter();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
